// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I main control FSM.
// Sequences fetch/decode/execute/memory/writeback over a shared memory port.
module multicycle_control_unit #(
    parameter bit ENABLE_JAL      = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b1,
    parameter int MEM_TIMEOUT     = 0,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       OPCode,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic [1:0]       PCSrc,
    output logic             IorD,
    output logic             IRWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [1:0]       MemtoReg,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             RegWrite,
    output logic             Branch,
    output logic             Illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD,
        S_MEMWB, S_MEMWR, S_EXECR, S_EXECI,
        S_ALUWB, S_BEQ, S_JAL, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam int TW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t           r_state;
    state_t           w_next;
    logic [TW-1:0]    r_wait;
    logic [CNT_W-1:0] r_retired;
    logic             w_wait_st;
    logic             w_timeout;
    logic             w_retire;

    assign w_wait_st = (r_state == S_FETCH) ||
                       (r_state == S_MEMRD) ||
                       (r_state == S_MEMWR);

    // mem_ready on the expiry cycle still advances normally
    assign w_timeout = (MEM_TIMEOUT > 0) && !mem_ready &&
                       (r_wait == TW'(MEM_TIMEOUT));

    // the illegal-NOP path (DECODE -> FETCH) is deliberately excluded
    assign w_retire = (w_next == S_FETCH) &&
                      ((r_state == S_MEMWB) || (r_state == S_MEMWR) ||
                       (r_state == S_ALUWB) || (r_state == S_BEQ) ||
                       (r_state == S_JAL));

    assign retired = r_retired;

    // state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    // wait counter: runs only while parked in a memory wait state
    always_ff @(posedge clk) begin
        if (reset)
            r_wait <= '0;
        else if ((MEM_TIMEOUT > 0) && w_wait_st && (w_next == r_state))
            r_wait <= r_wait + TW'(1);
        else
            r_wait <= '0;
    end

    // retired-instruction counter, wraps naturally
    always_ff @(posedge clk) begin
        if (reset)         r_retired <= '0;
        else if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end

    // next-state and Moore/Mealy control outputs
    always_comb begin
        w_next   = r_state;
        PCWrite  = 1'b0;
        PCSrc    = 2'b00;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 2'b00;
        ALUSrcA  = 2'b00;
        ALUSrcB  = 2'b00;
        ALUOp    = 2'b00;
        RegWrite = 1'b0;
        Branch   = 1'b0;
        Illegal  = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready)      w_next = S_DECODE;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_DECODE: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b10;
                if (OPCode == OP_LOAD || OPCode == OP_STORE)
                    w_next = S_MEMADR;
                else if (OPCode == OP_R)
                    w_next = S_EXECR;
                else if (OPCode == OP_I)
                    w_next = S_EXECI;
                else if (OPCode == OP_BEQ)
                    w_next = S_BEQ;
                else if (ENABLE_JAL && OPCode == OP_JAL)
                    w_next = S_JAL;
                else
                    w_next = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                w_next  = (OPCode == OP_LOAD) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready)      w_next = S_MEMWB;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
                w_next   = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready)      w_next = S_FETCH;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_EXECR: begin
                ALUSrcA = 2'b01;
                ALUOp   = 2'b10;
                w_next  = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b11;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_BEQ: begin
                Branch  = 1'b1;
                ALUSrcA = 2'b01;
                ALUOp   = 2'b01;
                PCSrc   = 2'b01;
                PCWrite = Zero;
                w_next  = S_FETCH;
            end
            S_JAL: begin
                PCSrc    = 2'b01;
                PCWrite  = 1'b1;
                RegWrite = 1'b1;
                MemtoReg = 2'b10;
                w_next   = S_FETCH;
            end
            S_TRAP: begin
                Illegal = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

endmodule
